// File: rtl/regfile_sequencer.sv
// ============================================================================
// Module      : regfile_sequencer
// Description : Initiator-side controller driving an 8x16 register file with
//               WRITE/READ/MOVE/SWAP commands over valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer #(
    parameter int W  = 16,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_rs,
    input  logic [W-1:0]  cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [W-1:0]  rsp_data,
    output logic          busy,
    output logic [W-1:0]  rf_data_in,
    output logic [AW-1:0] rf_writenum,
    output logic          rf_write,
    output logic [AW-1:0] rf_readnum,
    input  logic [W-1:0]  rf_data_out
);

    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_READ  = 2'b01;
    localparam logic [1:0] c_OP_MOVE  = 2'b10;
    localparam logic [1:0] c_OP_SWAP  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WR    = 4'd1,
        S_RD    = 4'd2,
        S_MV_R  = 4'd3,
        S_MV_W  = 4'd4,
        S_SW_RA = 4'd5,
        S_SW_RB = 4'd6,
        S_SW_WD = 4'd7,
        S_SW_WS = 4'd8,
        S_RESP  = 4'd9
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_rs;
    logic [W-1:0]  r_imm;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_rsp_data;

    logic          w_accept;
    logic          w_write;
    logic [AW-1:0] w_writenum;
    logic [W-1:0]  w_data_in;
    logic [AW-1:0] w_readnum;

    assign cmd_ready = (r_state == S_IDLE) & reset_n;
    assign w_accept  = cmd_valid & cmd_ready;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);

    // Gating by reset_n keeps an aborted command from committing a write on the reset edge.
    assign rf_write    = w_write & reset_n;
    assign rf_writenum = w_writenum;
    assign rf_data_in  = w_data_in;
    assign rf_readnum  = w_readnum;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rd       <= '0;
            r_rs       <= '0;
            r_imm      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rsp_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rd  <= cmd_rd;
                r_rs  <= cmd_rs;
                r_imm <= cmd_imm;
            end
            case (r_state)
                S_WR:    r_rsp_data <= r_imm;
                S_RD:    r_rsp_data <= rf_data_out;
                S_MV_R:  r_a        <= rf_data_out;
                S_MV_W:  r_rsp_data <= r_a;
                S_SW_RA: r_a        <= rf_data_out;
                S_SW_RB: r_b        <= rf_data_out;
                S_SW_WS: r_rsp_data <= r_b;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_writenum  = '0;
        w_data_in   = '0;
        w_readnum   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_WRITE: w_state_nxt = S_WR;
                        c_OP_READ:  w_state_nxt = S_RD;
                        c_OP_MOVE:  w_state_nxt = S_MV_R;
                        c_OP_SWAP:  w_state_nxt = S_SW_RA;
                        default:    w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_WR: begin
                w_write     = 1'b1;
                w_writenum  = r_rd;
                w_data_in   = r_imm;
                w_state_nxt = S_RESP;
            end
            S_RD: begin
                w_readnum   = r_rs;
                w_state_nxt = S_RESP;
            end
            S_MV_R: begin
                w_readnum   = r_rs;
                w_state_nxt = S_MV_W;
            end
            S_MV_W: begin
                w_write     = 1'b1;
                w_writenum  = r_rd;
                w_data_in   = r_a;
                w_state_nxt = S_RESP;
            end
            S_SW_RA: begin
                w_readnum   = r_rs;
                w_state_nxt = S_SW_RB;
            end
            S_SW_RB: begin
                w_readnum   = r_rd;
                w_state_nxt = S_SW_WD;
            end
            S_SW_WD: begin
                w_write     = 1'b1;
                w_writenum  = r_rd;
                w_data_in   = r_a;
                w_state_nxt = S_SW_WS;
            end
            S_SW_WS: begin
                w_write     = 1'b1;
                w_writenum  = r_rs;
                w_data_in   = r_b;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
// Module      : tb_regfile_sequencer
// Description : Self-checking bench with a register-file model and a
//               command-level reference model of regfile_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sequencer;

    localparam int W  = 16;
    localparam int AW = 3;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op    = 2'b00;
    logic [AW-1:0] cmd_rd    = '0;
    logic [AW-1:0] cmd_rs    = '0;
    logic [W-1:0]  cmd_imm   = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          busy;
    logic [W-1:0]  rf_data_in;
    logic [AW-1:0] rf_writenum;
    logic          rf_write;
    logic [AW-1:0] rf_readnum;
    logic [W-1:0]  rf_data_out;

    regfile_sequencer #(.W(W), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs      (cmd_rs),
        .cmd_imm     (cmd_imm),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .rf_data_in  (rf_data_in),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file attached to the sequencer.
    logic [W-1:0] rf_mem [0:7];
    always @(posedge clk) if (rf_write) rf_mem[rf_writenum] <= rf_data_in;
    assign rf_data_out = rf_mem[rf_readnum];

    int total = 0;
    int bad   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s", name, what);
    endfunction

    // Command-level reference: register contents plus pending responses.
    typedef struct {
        logic [W-1:0] data;
        int           vcyc;
    } exp_t;

    logic [W-1:0] mdl [0:7];
    exp_t         q[$];
    exp_t         e;
    int           cyc = 0;
    int           nexec;
    int           badidx;
    logic [W-1:0] ma, mb;
    logic         pv = 1'b0, pr = 1'b0;
    logic [W-1:0] pd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            check("rst_rf_write", {31'd0, rf_write}, 32'd0);
            q.delete();
            pv = 1'b0;
            pr = 1'b0;
        end else begin
            if (!rf_write) check("rf_idle_outputs", {13'd0, rf_writenum, rf_data_in}, 32'd0);
            check("cmd_ready_vs_busy", {31'd0, cmd_ready}, {31'd0, !busy});
            if (pv && !pr) begin
                check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
                check("rsp_hold_data", {16'd0, rsp_data}, {16'd0, pd});
            end
            if (rsp_valid && !pv) begin
                if (q.size() == 0) fail_now("rsp_unexpected", "rsp_valid=1 required no pending response");
                else check("rsp_latency_cycle", cyc, q[0].vcyc);
            end
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    fail_now("rsp_transfer", "transfer with no pending response");
                end else begin
                    check("rsp_data_model", {16'd0, rsp_data}, {16'd0, q[0].data});
                    void'(q.pop_front());
                    badidx = -1;
                    for (int i = 0; i < 8; i++)
                        if (rf_mem[i] !== mdl[i] && badidx < 0) badidx = i;
                    total++;
                    if (badidx >= 0) begin
                        bad++;
                        $display("FAIL rf_contents: R%0d got %0h required %0h",
                                 badidx, rf_mem[badidx], mdl[badidx]);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                case (cmd_op)
                    2'b00: begin mdl[cmd_rd] = cmd_imm; e.data = cmd_imm; nexec = 1; end
                    2'b01: begin e.data = mdl[cmd_rs]; nexec = 1; end
                    2'b10: begin e.data = mdl[cmd_rs]; mdl[cmd_rd] = mdl[cmd_rs]; nexec = 2; end
                    default: begin
                        ma = mdl[cmd_rs];
                        mb = mdl[cmd_rd];
                        mdl[cmd_rd] = ma;
                        mdl[cmd_rs] = mb;
                        e.data = mb;
                        nexec = 4;
                    end
                endcase
                e.vcyc = cyc + 1 + nexec;
                q.push_back(e);
            end
            pv = rsp_valid;
            pr = rsp_ready;
            pd = rsp_data;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input int rd, input int rs, input logic [W-1:0] imm);
        int n;
        logic [31:0] rdv, rsv;
        rdv = rd;
        rsv = rs;
        cmd_op    = op;
        cmd_rd    = rdv[AW-1:0];
        cmd_rs    = rsv[AW-1:0];
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step;
            n++;
        end
        if (!cmd_ready) fail_now("cmd_accept_timeout", "cmd_ready never rose");
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string name, input logic [W-1:0] exp);
        int n;
        rsp_ready = 1'b1;
        n = 0;
        while (!rsp_valid && n < 50) begin
            step;
            n++;
        end
        if (!rsp_valid) fail_now(name, "rsp_valid never rose");
        else check(name, {16'd0, rsp_data}, {16'd0, exp});
        step;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++) begin
            rf_mem[i] = '0;
            mdl[i]    = '0;
        end

        reset_n = 1'b0;
        step; step; step;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("reset_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("reset_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);

        // WRITE then READ R3
        issue(2'b00, 3, 0, 16'hABCD);
        check("t1_wr_strobe", {31'd0, rf_write}, 32'd1);
        check("t1_wr_num", {29'd0, rf_writenum}, 32'd3);
        check("t1_wr_data", {16'd0, rf_data_in}, 32'h0000ABCD);
        step;
        check("t1_wr_strobe_off", {31'd0, rf_write}, 32'd0);
        check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        get_rsp("t1_wr_rsp", 16'hABCD);
        issue(2'b01, 0, 3, 16'h0);
        get_rsp("t1_rd_rsp", 16'hABCD);

        // SWAP R1/R6
        issue(2'b00, 1, 0, 16'h0011); get_rsp("t2_wr1", 16'h0011);
        issue(2'b00, 6, 0, 16'h0066); get_rsp("t2_wr6", 16'h0066);
        issue(2'b11, 1, 6, 16'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step;
            n++;
        end
        check("t2_swap_latency", n, 32'd4);
        get_rsp("t2_swap_rsp", 16'h0011);
        issue(2'b01, 0, 1, 16'h0); get_rsp("t2_rd1", 16'h0066);
        issue(2'b01, 0, 6, 16'h0); get_rsp("t2_rd6", 16'h0011);

        // MOVE R0 -> R7
        issue(2'b00, 0, 0, 16'h8001); get_rsp("t3_wr0", 16'h8001);
        issue(2'b10, 7, 0, 16'h0);
        check("t3_mv_early0", {31'd0, rsp_valid}, 32'd0);
        step;
        check("t3_mv_early1", {31'd0, rsp_valid}, 32'd0);
        step;
        check("t3_mv_valid", {31'd0, rsp_valid}, 32'd1);
        get_rsp("t3_mv_rsp", 16'h8001);
        issue(2'b01, 0, 7, 16'h0); get_rsp("t3_rd7", 16'h8001);
        issue(2'b01, 0, 0, 16'h0); get_rsp("t3_rd0", 16'h8001);

        // READ with consumer stalled
        issue(2'b00, 2, 0, 16'h2222); get_rsp("t4_wr2", 16'h2222);
        issue(2'b01, 0, 2, 16'h0);
        step;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_valid", {31'd0, rsp_valid}, 32'd1);
            check("t4_stall_data", {16'd0, rsp_data}, 32'h00002222);
            check("t4_stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            step;
        end
        rsp_ready = 1'b1;
        check("t4_valid_6th", {31'd0, rsp_valid}, 32'd1);
        step;
        rsp_ready = 1'b0;
        check("t4_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

        // SWAP R4/R5 aborted by reset during the second write
        issue(2'b00, 4, 0, 16'h0044); get_rsp("t5_wr4", 16'h0044);
        issue(2'b00, 5, 0, 16'h0055); get_rsp("t5_wr5", 16'h0055);
        issue(2'b11, 4, 5, 16'h0);
        step; step; step;
        check("t5_ws_num", {29'd0, rf_writenum}, 32'd5);
        reset_n = 1'b0;
        step;
        check("t5_abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("t5_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        mdl[5] = 16'h0055;
        issue(2'b01, 0, 4, 16'h0); get_rsp("t5_rd4", 16'h0055);
        issue(2'b01, 0, 5, 16'h0); get_rsp("t5_rd5", 16'h0055);

        // Back-to-back with cmd_valid held high
        rsp_ready = 1'b1;
        cmd_op    = 2'b00;
        cmd_rd    = 3'd0;
        cmd_rs    = 3'd0;
        cmd_imm   = 16'h0001;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            step;
            n++;
        end
        if (!cmd_ready) fail_now("t6_first_accept", "cmd_ready never rose");
        step;
        cmd_op  = 2'b01;
        cmd_imm = 16'h0;
        n = 0;
        while (!cmd_ready && n < 20) begin
            step;
            n++;
        end
        check("t6_accept_gap", n, 32'd2);
        step;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step;
            n++;
        end
        check("t6_rd_rsp", {16'd0, rsp_data}, 32'h00000001);
        step;
        rsp_ready = 1'b0;

        step; step; step;
        check("pending_responses", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
